mac_accumulator: RTL
====================

Name: mac_accumulator

Overview:
Downstream consumer of the signed multiplier's product. It accepts one signed M+N-bit product per valid cycle and accumulates LEN products into a wide accumulator. It then rounds, shifts and saturates the sum to an OUT_W-bit signed result. The result is presented on a valid/ready output. Together with the multiplier, this forms the MAC datapath of a block-FIR / dot-product engine.

Parameters:
M, 26, multiplicand width (multi1)
N, 14, multiplier width (multi2)
P, M+N (40), product width; derived, not overridden
LEN, 16, products per accumulation block; power of two, at least 2
ACC_W, 48, accumulator width; must be at least P+clog2(LEN), so the accumulator never overflows internally
SHIFT, 16, right-shift applied to the final sum; at least 1
OUT_W, 24, output width, signed

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous flush of the accumulation and any pending output
in_valid  in  1  product is valid
in_ready  out  1  block can take a product this cycle
product  in  P  signed two's-complement product from the multiplier
out_valid  out  1  result available
out_ready  in  1  consumer takes the result
out_data  out  OUT_W  signed rounded/saturated block sum
out_sat  out  1  out_data was clipped; qualified by out_valid

Behaviour:
- Reset (rst=1 at a rising edge): state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, in_ready=1 from the next cycle.
- States:
  - ACCUM: in_ready=1. On in_valid & in_ready: sign-extend product to ACC_W and add it to acc; cnt+1.
  - Last product (cnt==LEN-1): register the final result from the combinational value acc+product, then clear acc and cnt and go to HOLD.
- Latency: out_valid rises the cycle after the LEN-th product is accepted. Throughput is LEN products per result plus at least 1 HOLD cycle.
- HOLD: out_valid=1 and in_ready=0. out_data and out_sat stay stable until out_valid & out_ready; on that handshake go to ACCUM. in_ready=1 again the cycle after the handshake.
- Final computation, with s = full ACC_W sum:
  - r = s + 2^(SHIFT-1) when rounding is enabled (see the optional feature), else r = s; r is computed at ACC_W+1 bits.
  - q = r >>> SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1: out_data = 2^(OUT_W-1)-1, out_sat=1.
  - If q < -2^(OUT_W-1): out_data = -2^(OUT_W-1), out_sat=1.
  - Otherwise out_data = q[OUT_W-1:0], out_sat=0.
- clear=1 in any state: the next cycle is ACCUM with acc=0, cnt=0, out_valid=0. A simultaneous in_valid product is dropped, and a pending HOLD result is discarded.
- Priority: rst > clear > normal operation.
- in_valid while in_ready=0 is ignored. The upstream holds the product until in_ready is high; the multiplier pipeline is stalled by upstream gating of its operands.
- A partial block, or a reset in the middle of a block, leaves no residue; the next block starts from acc=0.

Optional Feature:
- Macro MAC_ACC_ROUND_EN.
- Defined: round-half-up; add 2^(SHIFT-1) before the shift.
- Undefined: truncation (floor via arithmetic shift), and the rounding adder is not built.
- Saturation logic is present in both builds.

Decomposition:
- Shared package mac_pkg holds:
  - constants M, N, P=M+N, LEN, ACC_W, SHIFT, OUT_W, CNT_W=clog2(LEN);
  - the state encoding ACCUM=1'b0, HOLD=1'b1;
  - SAT_MAX and SAT_MIN as OUT_W-bit constants.
- The multiplier and its testbench use the same M and N.
- One sub-module, mac_round_sat: a purely combinational block mapping the ACC_W sum to {out_data, out_sat}, including the MAC_ACC_ROUND_EN conditional. It is reusable by later stages.

Test Plan:
- Multiplier vector: 16 products of -11888676 (330241 × -36), out_ready=1 -> out_valid one cycle after the 16th product; out_data=-2903; out_sat=0. The value is the same in both builds.
- Rounding: 16 products of 2048 (sum 32768) -> out_data=1 with MAC_ACC_ROUND_EN, 0 without; out_sat=0.
- Saturation:
  - 16 products of 2^38 -> out_data=8388607, out_sat=1.
  - 16 products of -2^39 -> out_data=-8388608, out_sat=1.
- Backpressure: complete a block with 16 products of 65536, hold out_ready=0 for 5 cycles -> in_ready=0, out_data=16 stable throughout. Raise out_ready -> one handshake; in_ready=1 on the next cycle.
- Clear and reset:
  - Assert clear after 7 products, then send 16 products of 65536 -> out_data=16; the earlier products leave no residue.
  - Assert clear in HOLD -> out_valid drops the next cycle.
  - Assert rst mid-block -> all outputs 0 and in_ready=1 after reset.
- Random: 1000 blocks with random in_valid/out_ready gaps, compared against a reference model of sum, round, shift and saturate -> exact match, no dropped or duplicated results.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants, state encoding and saturation limits for the MAC accumulator datapath.
package mac_pkg;

  localparam int M     = 26;
  localparam int N     = 14;
  localparam int P     = M + N;
  localparam int LEN   = 16;
  localparam int ACC_W = 48;
  localparam int SHIFT = 16;
  localparam int OUT_W = 24;
  localparam int CNT_W = $clog2(LEN);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_t;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

endpackage

// File: rtl/mac_round_sat.sv
// Combinational round / arithmetic-shift / saturate from the ACC_W sum to OUT_W signed.
// Build option MAC_ACC_ROUND_EN: round-half-up; otherwise plain floor truncation.
module mac_round_sat
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0] i_sum,
  output logic [OUT_W-1:0] o_data,
  output logic             o_sat
);

  logic signed [ACC_W:0] w_r;
  logic signed [ACC_W:0] w_q;
  logic                  w_in_range;

`ifdef MAC_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_K = (ACC_W+1)'(1) << (SHIFT-1);
  assign w_r = $signed({i_sum[ACC_W-1], i_sum}) + ROUND_K;
`else
  assign w_r = $signed({i_sum[ACC_W-1], i_sum});
`endif

  assign w_q = w_r >>> SHIFT;

  // q fits when every bit above the OUT_W sign bit equals that sign bit
  assign w_in_range = (&w_q[ACC_W:OUT_W-1]) | ~(|w_q[ACC_W:OUT_W-1]);

  always_comb begin
    o_data = w_q[OUT_W-1:0];
    o_sat  = 1'b0;
    if (!w_in_range) begin
      o_sat  = 1'b1;
      o_data = w_q[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates LEN signed products per block, then presents the rounded/saturated sum on valid/ready.
// Rounding is selected by build option MAC_ACC_ROUND_EN (default: truncation).
//   state | meaning
//   ACCUM | taking products, in_ready=1
//   HOLD  | result presented, in_ready=0, waiting for out_ready
module mac_accumulator
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P-1:0]     product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  mac_state_t       r_state;
  mac_state_t       w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_sat;

  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_accept;
  logic             w_last;
  logic [OUT_W-1:0] w_rs_data;
  logic             w_rs_sat;

  assign in_ready   = (r_state == ACCUM);
  assign out_valid  = (r_state == HOLD);
  assign out_data   = r_out_data;
  assign out_sat    = r_out_sat;

  assign w_prod_ext = {{(ACC_W-P){product[P-1]}}, product};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_accept   = in_valid & in_ready;
  assign w_last     = w_accept & (r_cnt == CNT_W'(LEN-1));

  // final result is taken from acc+product so the last product needs no extra cycle
  mac_round_sat u_round_sat (
    .i_sum  (w_sum),
    .o_data (w_rs_data),
    .o_sat  (w_rs_sat)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ACCUM: if (w_last) w_state_next = HOLD;
      HOLD:  if (out_ready) w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
    if (clear) w_state_next = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else if (clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_last) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_out_data <= w_rs_data;
      r_out_sat  <= w_rs_sat;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
